// File: rtl/noobs_dmem_pkg.sv
// rtl/noobs_dmem_pkg.sv - shared constants and helpers for the noobs data-memory arbiter
package noobs_dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int PERF_CNT_W = 16;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/noobs_rr_arbiter.sv
// rtl/noobs_rr_arbiter.sv - combinational round-robin picker, search starts just above last_grant
module noobs_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // One extra bit of headroom so last_grant + k never wraps before the modulo fold.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/noobs_dmem_arb.sv
// rtl/noobs_dmem_arb.sv - N-master round-robin data-memory port arbiter with wait states
// Optional perf counters: define NOOBS_DMEM_ARB_PERF_CNT_EN.
module noobs_dmem_arb
    import noobs_dmem_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       busy,
    output logic                       m_en,
    output logic                       m_rd,
    output logic                       m_wr,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wr_data,
    input  logic [DATA_W-1:0]          m_rd_data
`ifdef NOOBS_DMEM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0] grant_cnt,
    output logic [NUM_REQ*PERF_CNT_W-1:0] stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]        state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  win_q;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              in_access;
    logic              in_resp;

    // Gating with reset keeps req_ready low while a reset is being sampled.
    noobs_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         ((state == ST_IDLE) && !reset),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            win_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        win_q      <= grant_idx;
                        last_grant <= grant_idx;
                        wr_q       <= req_wr[grant_idx];
                        addr_q     <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                        wdata_q    <= req_wdata[grant_idx*DATA_W +: DATA_W];
                        wait_cnt   <= 4'(WAIT_STATES);
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!wr_q) begin
                        rdata_q <= m_rd_data;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    assign req_ready = grant;
    assign busy      = in_access | in_resp;
    assign m_en      = in_access;
    assign m_rd      = in_access & ~wr_q;
    assign m_wr      = in_access & wr_q;
    assign m_addr    = in_access ? addr_q : '0;
    assign m_wr_data = in_access ? wdata_q : '0;
    assign rsp_valid = in_resp ? (NUM_REQ'(1) << win_q) : '0;
    assign rsp_rdata = (in_resp && !wr_q) ? m_rd_data : rdata_q;

`ifdef NOOBS_DMEM_ARB_PERF_CNT_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [PERF_CNT_W-1:0] gcnt;
        logic [PERF_CNT_W-1:0] scnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                gcnt <= '0;
                scnt <= '0;
            end else begin
                if (grant[g]) begin
                    gcnt <= sat_inc(gcnt);
                end
                if (req_valid[g] && !grant[g]) begin
                    scnt <= sat_inc(scnt);
                end
            end
        end

        assign grant_cnt[g*PERF_CNT_W +: PERF_CNT_W] = gcnt;
        assign stall_cnt[g*PERF_CNT_W +: PERF_CNT_W] = scnt;
    end
`endif

endmodule

// File: doc/noobs_dmem_arb.md
Name: noobs_dmem_arb

Overview:
- Parametrised data-memory port arbiter that sits between NUM_REQ data-side masters and the single synchronous data memory port of the noobs CPU system.
- Typical masters: CPU execute data port, a DMA engine, a debug loader.
- Generalises the single-master m_en/m_rd/m_wr interface in four ways: N requesters, round-robin arbitration, parametrised address/data widths, and configurable memory wait states.
- Every transaction ends with an explicit per-requester response pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 12, address width.
- DATA_W, 8, data width.
- WAIT_STATES, 0, extra cycles the memory strobes are held beyond 1 (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data, shared across requesters, qualified by rsp_valid.
- busy  out  1  arbiter not idle.
- m_en  out  1  memory enable.
- m_rd  out  1  memory read strobe.
- m_wr  out  1  memory write strobe.
- m_addr  out  ADDR_W  memory address.
- m_wr_data  out  DATA_W  memory write data.
- m_rd_data  in  DATA_W  memory read data, valid the cycle after the last read strobe cycle.

Behaviour:
- Reset (synchronous, active-high; clk and reset as stated in Ports):
  - All outputs go to 0; FSM goes to IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts it with no rsp_valid, and memory strobes drop the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, pick winner w = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[w]=1 combinationally in this cycle only.
  - Latch w, req_wr[w], req_addr slice and req_wdata slice; set last_grant=w; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - m_en=1, m_rd=~wr_q, m_wr=wr_q, m_addr/m_wr_data from the latched values, all stable for exactly 1+WAIT_STATES cycles.
  - A wait counter loaded with WAIT_STATES decrements each cycle; leave to RESP when it reaches 0.
- RESP (one cycle):
  - m_* = 0; rsp_valid[w]=1.
  - For a read, rsp_rdata = m_rd_data sampled this cycle. For a write, rsp_rdata holds its previous value.
  - Return to IDLE.
- busy = 1 in ACCESS and RESP.
- Throughput: one transaction per 3+WAIT_STATES cycles. Back-to-back requests are re-arbitrated in each IDLE cycle.
- Requester rules:
  - Hold valid, wr, addr and wdata stable until req_ready.
  - Dropping valid before ready is legal and creates no transaction.
  - A requester may issue its next request in the cycle rsp_valid is high; it is seen in the following IDLE.
- Simultaneous requests: round-robin guarantees each active requester is granted within NUM_REQ transactions.
- m_rd and m_wr are never both 1. Bench assertion: never (m_en & m_rd & m_wr).
- req_ready and rsp_valid are always at most one-hot.

Optional Feature:
- Macro NOOBS_DMEM_ARB_PERF_CNT_EN.
- When defined, add:
  - Output grant_cnt, NUM_REQ*16 bits: per-requester saturating 16-bit count of req_ready pulses.
  - Output stall_cnt, NUM_REQ*16 bits: per-requester saturating count of cycles with req_valid=1 and req_ready=0.
  - Both counters reset to 0 and saturate at 16'hFFFF.
- When not defined, the ports and logic are absent.

Decomposition:
- Shared package noobs_dmem_pkg holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Default ADDR_W/DATA_W constants.
  - Counter width constant PERF_CNT_W=16.
- One sub-module: noobs_rr_arbiter (parametrised NUM_REQ; inputs req vector, last_grant, enable; outputs one-hot grant and binary index). It is reusable by other shared resources.

Test Plan:
- Single read, WAIT_STATES=0: req0 reads addr 12'h055, memory returns 8'hA5. Required: req_ready[0] in cycle 0; m_en=1/m_rd=1/m_addr=12'h055 in cycle 1; rsp_valid[0]=1 and rsp_rdata=8'hA5 in cycle 2.
- Write with WAIT_STATES=3: req1 writes 8'h3C to 12'h7FF. Required: m_wr=1 with stable addr/data for exactly 4 cycles; m_rd=0 throughout; rsp_valid[1] one cycle later; rsp_rdata unchanged.
- Contention, NUM_REQ=3, all requesters valid continuously. Required: grant order 0,1,2,0,1,2; each transaction 3 cycles apart; no two req_ready bits set together.
- Reset mid-ACCESS with WAIT_STATES=5: assert reset on the 2nd access cycle. Required: next cycle all outputs 0, no rsp_valid, and the next grant goes to requester 0.
- Valid withdrawn: req0 valid for 1 cycle while arbiter busy with req1, then dropped. Required: req0 never granted; arbiter returns to IDLE with busy=0.
- Perf counters, macro defined: req1 waits 4 cycles behind req0. Required: stall_cnt[1]=4, grant_cnt[0]=1, grant_cnt[1]=1.
